fp16_to_fixed: RTL and testbench

Iterative decoder from IEEE-754 binary16 to sign-magnitude fixed point (16-bit integer part plus FRAC_W-bit fraction). It is the inverse of the real-to-half encoding that feeds fpa operands. It unpacks fpa results into integer and fraction fields for checkers and downstream fixed-point logic. The datapath is a single shift register that moves one bit position per cycle, with valid/ready handshakes on both sides.

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/fp16_classify.sv | 34 +++
 rtl/fp16_to_fixed.sv | 113 +++++++++++
 tb/tb_fp16_to_fixed.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, classification and FSM state types.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam int INT_W   = 16;

  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} cls_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [EXP_W-1:0] exp_of(input logic [15:0] x);
    return x[14:10];
  endfunction

  function automatic logic [MAN_W-1:0] man_of(input logic [15:0] x);
    return x[9:0];
  endfunction

  function automatic logic sign_of(input logic [15:0] x);
    return x[15];
  endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 classifier: class, signed shift to fixed point, loaded mantissa.
module fp16_classify
  import fp16_pkg::*;
#(
  parameter int FRAC_W = 16
) (
  input  logic [15:0]       fp,
  output cls_t              cls,
  output logic signed [7:0] shamt,
  output logic [MAN_W:0]    man
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  int               sv;

  always_comb begin
    e     = exp_of(fp);
    m     = man_of(fp);
    cls   = CLS_NORM;
    man   = {1'b1, m};
    sv    = int'(e) - BIAS - MAN_W + FRAC_W;
    if (e == '0) begin
      // subnormals share the exponent of e = 1 but lack the hidden bit
      man = {1'b0, m};
      sv  = 1 - BIAS - MAN_W + FRAC_W;
      cls = (m == '0) ? CLS_ZERO : CLS_SUB;
    end else if (e == EXP_W'(EXP_MAX)) begin
      cls = (m == '0) ? CLS_INF : CLS_NAN;
    end
    shamt = 8'(sv);
  end

endmodule

// File: rtl/fp16_to_fixed.sv
// Iterative binary16 to sign-magnitude fixed-point decoder, one bit shift per cycle.
module fp16_to_fixed
  import fp16_pkg::*;
#(
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [INT_W-1:0]  out_int,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_inexact,
  output logic              out_zero,
  output logic              out_inf,
  output logic              out_nan
);

  localparam int MW = INT_W + FRAC_W;

  state_t            state, state_n;
  cls_t              cls;
  logic signed [7:0] shamt;
  logic [MAN_W:0]    man;
  logic [MW-1:0]     mag, mag_n, ld;
  logic [5:0]        cnt;
  logic              left, sticky, sticky_n, pend_sign, special;

  fp16_classify #(.FRAC_W(FRAC_W)) u_cls (
    .fp    (in_data),
    .cls   (cls),
    .shamt (shamt),
    .man   (man)
  );

  always_comb begin
    special  = (cls == CLS_ZERO) || (cls == CLS_INF) || (cls == CLS_NAN);
    ld       = MW'(man);
    mag_n    = left ? {mag[MW-2:0], 1'b0} : {1'b0, mag[MW-1:1]};
    sticky_n = sticky | (~left & mag[0]);
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:  if (in_valid) state_n = (special || shamt == '0) ? DONE : SHIFT;
      SHIFT: if (cnt == 6'd1) state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mag         <= '0;
      cnt         <= '0;
      left        <= 1'b0;
      sticky      <= 1'b0;
      pend_sign   <= 1'b0;
      out_sign    <= 1'b0;
      out_int     <= '0;
      out_frac    <= '0;
      out_inexact <= 1'b0;
      out_zero    <= 1'b0;
      out_inf     <= 1'b0;
      out_nan     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          mag       <= ld;
          cnt       <= 6'((shamt < 0) ? -shamt : shamt);
          left      <= (shamt > 0);
          sticky    <= 1'b0;
          pend_sign <= sign_of(in_data);
          // results needing no shift are published straight from the classifier
          if (special || shamt == '0) begin
            out_sign    <= sign_of(in_data);
            out_int     <= special ? '0 : ld[MW-1:FRAC_W];
            out_frac    <= special ? '0 : ld[FRAC_W-1:0];
            out_inexact <= 1'b0;
            out_zero    <= (cls == CLS_ZERO);
            out_inf     <= (cls == CLS_INF);
            out_nan     <= (cls == CLS_NAN);
          end
        end
        SHIFT: begin
          mag    <= mag_n;
          sticky <= sticky_n;
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            out_sign    <= pend_sign;
            out_int     <= mag_n[MW-1:FRAC_W];
            out_frac    <= mag_n[FRAC_W-1:0];
            out_inexact <= sticky_n;
            out_zero    <= 1'b0;
            out_inf     <= 1'b0;
            out_nan     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Scoreboard bench for fp16_to_fixed: values, flags, latency, backpressure and reset abort.
module tb_fp16_to_fixed;

  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [15:0]   out_int;
  logic [FW-1:0] out_frac;
  logic          out_inexact, out_zero, out_inf, out_nan;

  fp16_to_fixed #(.FRAC_W(FW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_int     (out_int),
    .out_frac    (out_frac),
    .out_inexact (out_inexact),
    .out_zero    (out_zero),
    .out_inf     (out_inf),
    .out_nan     (out_nan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sign;
    logic [15:0]   ival;
    logic [FW-1:0] fval;
    logic          inx, z, inf, nan;
    longint        due;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  int     popped = 0;
  int     npop = 0;
  longint cyc = 0;
  longint seen_edge = 0;
  logic   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Value = mant * 2^(e-25), scaled by 2^FW into a 64-bit fixed-point number.
  function automatic exp_t model(input logic [15:0] d, input longint acc);
    exp_t   r;
    int     e, sh;
    longint mm, v;
    e = int'(d[14:10]);
    r.sign = d[15];
    r.ival = '0; r.fval = '0; r.inx = 1'b0; r.z = 1'b0; r.inf = 1'b0; r.nan = 1'b0;
    r.due = acc + 1;
    if (e == 31) begin
      r.inf = (d[9:0] == 0);
      r.nan = (d[9:0] != 0);
    end else if (e == 0 && d[9:0] == 0) begin
      r.z = 1'b1;
    end else begin
      mm = (e == 0) ? longint'(d[9:0]) : longint'(d[9:0]) + 1024;
      sh = ((e == 0) ? 1 : e) - 25 + FW;
      if (sh >= 0) v = mm << sh;
      else begin
        v = mm >> (-sh);
        r.inx = ((mm & ((64'd1 << (-sh)) - 1)) != 0);
      end
      r.ival = 16'(v >> FW);
      r.fval = FW'(v);
      r.due = acc + 1 + ((sh < 0) ? -sh : sh);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) sb.push_back(model(in_data, cyc + 1));
      if (out_valid && !prev_valid) seen_edge = cyc + 1;
      if (out_valid && sb.size() == 0) check("unexpected_valid", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        check("sign",    64'(out_sign),    64'(x.sign));
        check("int",     64'(out_int),     64'(x.ival));
        check("frac",    64'(out_frac),    64'(x.fval));
        check("inexact", 64'(out_inexact), 64'(x.inx));
        check("zero",    64'(out_zero),    64'(x.z));
        check("inf",     64'(out_inf),     64'(x.inf));
        check("nan",     64'(out_nan),     64'(x.nan));
        check("latency", 64'(seen_edge),   64'(x.due));
        popped++;
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [15:0] d);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    else npop++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_pop();
    int n = 0;
    while (popped < npop && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (popped < npop) check("result_timeout", 64'(popped), 64'(npop));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_fields"}, {out_sign, out_int, out_frac, out_inexact, out_zero, out_inf, out_nan}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("reset");

    send(16'h4300);
    wait_pop();
    send(16'h4480);
    send(16'hB800);
    wait_pop();
    send(16'h7BFF);
    wait_pop();
    send(16'h0001);
    wait_pop();
    send(16'h7C00);
    send(16'h7E00);
    send(16'h8000);
    send(16'h0000);
    send(16'h03FF);
    send(16'h0400);
    wait_pop();
    for (int i = 0; i < 20; i++) begin
      logic [15:0] d;
      d = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
      send(d);
    end
    wait_pop();

    out_ready = 1'b0;
    send(16'h4300);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin in_valid = 1'b1; in_data = 16'h3C00; end
      if (k == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_fields", {out_sign, out_int, out_frac, out_inexact, out_zero, out_inf, out_nan},
            {1'b0, 16'd3, 16'h8000, 4'b0000});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_return", 64'(in_ready), 64'd1);
    wait_pop();

    send(16'h7BFF);
    npop--;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("abort");
    repeat (30) @(posedge clk);
    #1 check("abort_no_valid", 64'(out_valid), 64'd0);
    send(16'h3C00);
    wait_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
